// File: rtl/axi_read_burst_scheduler.sv
// Splits a read transfer of req_beats 32-bit beats into AXI bursts.
// Each burst is capped at MAX_BURST_BEATS and never crosses a 4 KB page.
module axi_read_burst_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int TOTAL_WIDTH     = 16,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [TOTAL_WIDTH-1:0]    req_beats,
  output logic                      busy,
  output logic                      xfer_done,
  output logic [TOTAL_WIDTH-1:0]    burst_count,
  output logic                      rd_start,
  output logic [ADDR_WIDTH-1:0]     rd_target_addr,
  output logic [READ_BURST_LEN-1:0] rd_target_burst_len,
  input  logic                      rd_done
);

  // Wide enough for the beat count and for the 1..1024 beats left in a page.
  localparam int CW = (TOTAL_WIDTH > 11) ? TOTAL_WIDTH : 11;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [TOTAL_WIDTH-1:0]  remaining;
  logic [CW-1:0]           burst_beats;
  logic [CW-1:0]           page_left, b_calc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rd_start  = 1'b0;
    xfer_done = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_beats != '0) ? CALC : FINISH;
      end
      CALC:      state_d = ISSUE;
      ISSUE: begin
        rd_start = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (rd_done)
          state_d = (remaining == TOTAL_WIDTH'(burst_beats)) ? FINISH : CALC;
      end
      FINISH: begin
        xfer_done = 1'b1;
        state_d   = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Burst size: smallest of beats remaining, the burst cap and the room left in the page.
  always_comb begin
    page_left = CW'(1024) - CW'(addr_q[11:2]);
    b_calc    = CW'(remaining);
    if (CW'(MAX_BURST_BEATS) < b_calc) b_calc = CW'(MAX_BURST_BEATS);
    if (page_left < b_calc)            b_calc = page_left;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q              <= '0;
      remaining           <= '0;
      burst_beats         <= '0;
      burst_count         <= '0;
      rd_target_addr      <= '0;
      rd_target_burst_len <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr & ~ADDR_WIDTH'(3);
            remaining   <= req_beats;
            burst_count <= '0;
          end
        end
        CALC: begin
          burst_beats         <= b_calc;
          rd_target_addr      <= addr_q;
          rd_target_burst_len <= READ_BURST_LEN'(b_calc - CW'(1));
        end
        WAIT_DONE: begin
          if (rd_done) begin
            addr_q      <= addr_q + ADDR_WIDTH'({burst_beats, 2'b00});
            remaining   <= remaining - TOTAL_WIDTH'(burst_beats);
            burst_count <= burst_count + TOTAL_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_burst_scheduler.sv
// Directed bench for axi_read_burst_scheduler; the bench plays the read channel.
module tb_axi_read_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_beats = '0;
  logic        busy, xfer_done, rd_start, rd_done = 1'b0;
  logic [15:0] burst_count;
  logic [31:0] rd_target_addr;
  logic [7:0]  rd_target_burst_len;

  int checks = 0;
  int failures = 0;

  axi_read_burst_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats),
    .busy(busy), .xfer_done(xfer_done), .burst_count(burst_count),
    .rd_start(rd_start), .rd_target_addr(rd_target_addr),
    .rd_target_burst_len(rd_target_burst_len), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_beats = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!rd_start && k < 20);
    if (!rd_start) k = 99;
  endtask

  task automatic wait_xfer(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!xfer_done && k < 20);
    if (!xfer_done) k = 99;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 rd_done = 1'b1;
    @(posedge clk); #1 rd_done = 1'b0;
  endtask

  // Expect one burst two cycles after the previous accept/rd_done, answer it,
  // and on the last burst expect xfer_done one cycle after rd_done.
  task automatic serve(input logic [31:0] a, input logic [7:0] l, input bit last,
                       input string tag);
    int k;
    wait_start(k);
    chk({tag, ".lat"}, k, 2);
    chk({tag, ".addr"}, rd_target_addr, a);
    chk({tag, ".len"}, rd_target_burst_len, l);
    @(negedge clk);
    chk({tag, ".start_1cyc"}, rd_start, 0);
    chk({tag, ".ready_busy"}, {req_ready, busy}, 2'b01);
    chk({tag, ".addr_hold"}, rd_target_addr, a);
    pulse_done();
    if (last) begin
      wait_xfer(k);
      chk({tag, ".done_lat"}, k, 1);
    end
  endtask

  initial begin
    int k;
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.outs", {busy, xfer_done, rd_start}, 3'b000);
    chk("rst.cnt", burst_count, 0);
    chk("rst.tgt", {rd_target_addr, rd_target_burst_len}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", req_ready, 1);

    // 40 beats from 0x1000: 16 + 16 + 8
    start_req(32'h1000, 16'd40);
    serve(32'h1000, 8'd15, 1'b0, "t1.b0");
    serve(32'h1040, 8'd15, 1'b0, "t1.b1");
    serve(32'h1080, 8'd7,  1'b1, "t1.b2");
    chk("t1.cnt", burst_count, 3);
    repeat (3) @(negedge clk);
    chk("t1.cnt_hold", burst_count, 3);
    chk("t1.idle", {req_ready, busy}, 2'b10);

    // 4 KB boundary: 4 beats to page end, then 6
    start_req(32'h0FF0, 16'd10);
    serve(32'h0FF0, 8'd3, 1'b0, "t2.b0");
    serve(32'h1000, 8'd5, 1'b1, "t2.b1");
    chk("t2.cnt", burst_count, 2);

    // Unaligned single beat
    start_req(32'h2003, 16'd1);
    serve(32'h2000, 8'd0, 1'b1, "t3.b0");
    chk("t3.cnt", burst_count, 1);

    // Zero beats: xfer_done at N+1, ready again at N+2
    start_req(32'h3000, 16'd0);
    @(negedge clk);
    chk("t4.done", {xfer_done, rd_start}, 2'b10);
    chk("t4.cnt", burst_count, 0);
    @(negedge clk);
    chk("t4.ready", {req_ready, xfer_done, rd_start}, 3'b100);

    // Competing request held during the transfer is ignored
    start_req(32'h1000, 16'd40);
    #1 req_valid = 1'b1; req_addr = 32'h5000; req_beats = 16'd7;
    serve(32'h1000, 8'd15, 1'b0, "t5.b0");
    serve(32'h1040, 8'd15, 1'b0, "t5.b1");
    req_valid = 1'b0;
    serve(32'h1080, 8'd7, 1'b1, "t5.b2");
    chk("t5.cnt", burst_count, 3);

    // Reset during WAIT_DONE of burst 2 of 3; stale rd_done ignored
    start_req(32'h1000, 16'd40);
    serve(32'h1000, 8'd15, 1'b0, "t6.b0");
    wait_start(k);
    chk("t6.b1.lat", k, 2);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6.rst", {busy, rd_start, req_ready}, 3'b001);
    chk("t6.rst_cnt", burst_count, 0);
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6.stale", {busy, xfer_done, rd_start}, 3'b000);
      chk("t6.stale_cnt", burst_count, 0);
    end

    // Recovery after mid-transfer reset
    start_req(32'h0FFC, 16'd3);
    serve(32'h0FFC, 8'd0, 1'b0, "t7.b0");
    serve(32'h1000, 8'd1, 1'b1, "t7.b1");
    chk("t7.cnt", burst_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
